// File: rtl/commit_stage_pkg.sv
// commit_stage_pkg: shared widths and ROB / CDB / store-buffer entry types.
package commit_stage_pkg;
  localparam int XLEN         = 32;
  localparam int ROB_TAG_LEN  = 4;
  localparam int SB_DEPTH_DEF = 4;
  typedef struct packed {
    logic            valid;
    logic            wr_mem;
    logic [4:0]      dest_reg;
    logic [XLEN-1:0] value;
    logic [XLEN-1:0] dest_addr;
    logic [2:0]      mem_size;
  } ROB_ENTRY;
  typedef struct packed {
    logic                   valid;
    logic [ROB_TAG_LEN-1:0] tag;
    logic [XLEN-1:0]        value;
  } CDB_DATA;
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [2:0]      size;
  } SB_ENTRY;
endpackage

// File: rtl/commit_stage_store_buffer.sv
// store_buffer: circular FIFO of committed stores with an address-match CAM.
// Ports: i_clock, i_reset (active low, sync); i_push/i_push_entry write at tail;
// i_pop retires the head; o_head oldest entry; o_count/o_full/o_empty occupancy;
// i_match_addr/o_match hit against occupied entries only.
module store_buffer
  import commit_stage_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEF
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_push,
  input  SB_ENTRY                i_push_entry,
  input  logic                   i_pop,
  input  logic [XLEN-1:0]        i_match_addr,
  output SB_ENTRY                o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty,
  output logic                   o_match
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  SB_ENTRY       r_mem [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic [PW-1:0] w_off [DEPTH];
  logic          w_push, w_pop;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_full  = r_count == CW'(DEPTH);
  assign o_empty = r_count == '0;
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wptr] <= i_push_entry;
  end
  // A slot is occupied when its distance from the read pointer (mod DEPTH) is below the count.
  always_comb begin
    o_match = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      w_off[k] = PW'(k) - r_rptr;
      o_match  = o_match | (({1'b0, w_off[k]} < r_count) && (r_mem[k].addr == i_match_addr));
    end
  end
endmodule

// File: rtl/commit_stage.sv
// commit_stage: in-order retirement of the ROB head into the register file or the store buffer.
// Ports: i_clock, i_reset (active low, sync); i_rob_head_* ROB head; o_commit_pop head consumed;
// o_rf_wr_* register write; o_retire_* map-table clear; o_mem_req_*/i_mem_req_ack store drain;
// i_load_check_addr/o_load_sb_hit load disambiguation; o_sb_count/o_sb_empty; o_retired_count.
module commit_stage
  import commit_stage_pkg::*;
#(
  parameter int SB_DEPTH = SB_DEPTH_DEF,
  parameter int CNT_W    = 64
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  ROB_ENTRY                  i_rob_head_entry,
  input  logic [ROB_TAG_LEN-1:0]    i_rob_head_tag,
  input  logic                      i_rob_head_ready,
  output logic                      o_commit_pop,
  output logic                      o_rf_wr_en,
  output logic [4:0]                o_rf_wr_idx,
  output logic [XLEN-1:0]           o_rf_wr_data,
  output logic                      o_retire_valid,
  output logic [ROB_TAG_LEN-1:0]    o_retire_tag,
  output logic                      o_mem_req_valid,
  output logic [XLEN-1:0]           o_mem_req_addr,
  output logic [XLEN-1:0]           o_mem_req_data,
  output logic [2:0]                o_mem_req_size,
  input  logic                      i_mem_req_ack,
  input  logic [XLEN-1:0]           i_load_check_addr,
  output logic                      o_load_sb_hit,
  output logic [$clog2(SB_DEPTH):0] o_sb_count,
  output logic                      o_sb_empty,
  output logic [CNT_W-1:0]          o_retired_count
);
  logic             w_can_commit, w_sb_full, w_sb_match, w_sb_push, w_sb_pop;
  SB_ENTRY          w_sb_head;
  logic [CNT_W-1:0] r_retired;
  // Full is judged on the registered count, so an ack this cycle cannot make room for a push this cycle.
  always_comb begin
    w_can_commit    = i_reset && i_rob_head_entry.valid && i_rob_head_ready;
    o_commit_pop    = w_can_commit && (!i_rob_head_entry.wr_mem || !w_sb_full);
    w_sb_push       = o_commit_pop && i_rob_head_entry.wr_mem;
    o_rf_wr_en      = o_commit_pop && !i_rob_head_entry.wr_mem && (i_rob_head_entry.dest_reg != 5'd0);
    o_rf_wr_idx     = i_rob_head_entry.dest_reg;
    o_rf_wr_data    = i_rob_head_entry.value;
    o_retire_valid  = o_commit_pop;
    o_retire_tag    = i_rob_head_tag;
    o_mem_req_valid = i_reset && !o_sb_empty;
    o_mem_req_addr  = w_sb_head.addr;
    o_mem_req_data  = w_sb_head.data;
    o_mem_req_size  = w_sb_head.size;
    w_sb_pop        = i_mem_req_ack && o_mem_req_valid;
    o_load_sb_hit   = i_reset && w_sb_match;
  end
  always_ff @(posedge i_clock) begin
    if (!i_reset) r_retired <= '0;
    else if (o_commit_pop) r_retired <= r_retired + 1'b1;
  end
  assign o_retired_count = r_retired;
  store_buffer #(.DEPTH(SB_DEPTH)) u_sb (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_push       (w_sb_push),
    .i_push_entry ('{addr: i_rob_head_entry.dest_addr, data: i_rob_head_entry.value, size: i_rob_head_entry.mem_size}),
    .i_pop        (w_sb_pop),
    .i_match_addr (i_load_check_addr),
    .o_head       (w_sb_head),
    .o_count      (o_sb_count),
    .o_full       (w_sb_full),
    .o_empty      (o_sb_empty),
    .o_match      (w_sb_match)
  );
endmodule
